// File: rtl/sigmoid_pkg.sv
// Shared constants and types for the sigmoid activation / classifier slice.
// Contents: float32 constants, NaN exponent pattern, classifier FSM state enum.
package sigmoid_pkg;

  localparam int unsigned FP_W      = 32;
  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_MANT_W = 23;

  localparam logic [FP_W-1:0]     FP_ZERO    = 32'h0000_0000;
  localparam logic [FP_W-1:0]     FP_HALF    = 32'h3F00_0000;
  localparam logic [FP_W-1:0]     FP_ONE     = 32'h3F80_0000;
  localparam logic [FP_EXP_W-1:0] FP_EXP_NAN = 8'hFF;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/sigmoid_argmax_if.sv
// Beat-input and result-output handshake bundle of the argmax classifier.
// master: upstream/downstream side (drives in_*, out_ready).
// slave : classifier side (drives in_ready, out_*).
interface sigmoid_argmax_if #(
  parameter int unsigned NUM_CLASSES = 10
);
  localparam int unsigned IDX_W = $clog2(NUM_CLASSES);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [31:0]      out_value;
  logic             out_confident;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_index, out_value, out_confident, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_index, out_value, out_confident, out_err
  );

endinterface

// File: rtl/fp_pos_gt.sv
// Combinational compare of float32 a against b for non-negative values.
// Ports: a, b (float32); a_valid (a is +0..+inf, not NaN);
//        a_gt_b / a_ge_b (31-bit magnitude compare, sign ignored).
// For positive IEEE-754 values the magnitude bits order like unsigned ints.
module fp_pos_gt
  import sigmoid_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            a_valid,
  output logic            a_gt_b,
  output logic            a_ge_b
);

  logic a_is_nan;

  always_comb begin
    a_is_nan = (a[FP_W-2 -: FP_EXP_W] == FP_EXP_NAN) && (a[FP_MANT_W-1:0] != '0);
    a_valid  = !a[FP_W-1] && !a_is_nan;
    a_gt_b   = a[FP_W-2:0] >  b[FP_W-2:0];
    a_ge_b   = a[FP_W-2:0] >= b[FP_W-2:0];
  end

endmodule

// File: rtl/sigmoid_argmax.sv
// Output-layer argmax over a serial frame of NUM_CLASSES float32 activations.
// Ports: clk, rst_n (async active-low); bus (slave) carries the beat input
//        (in_valid/in_ready/in_data/in_last) and the held result
//        (out_valid/out_ready/out_index/out_value/out_confident/out_err);
//        frame_count counts accepted results, wrapping at 16 bits.
module sigmoid_argmax
  import sigmoid_pkg::*;
#(
  parameter int unsigned     NUM_CLASSES = 10,
  parameter logic [FP_W-1:0] THRESH      = FP_HALF
) (
  input  logic              clk,
  input  logic              rst_n,
  sigmoid_argmax_if.slave   bus,
  output logic [15:0]       frame_count
);

  localparam int unsigned      IDX_W    = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q;
  logic [FP_W-1:0]   best_val_q;
  logic [IDX_W-1:0]  best_idx_q;
  logic              any_valid_q;

  logic              accept;
  logic              at_end;
  logic              frame_end;
  logic              frame_err;
  logic              release_res;
  logic              beat_valid, beat_gt, beat_ge_unused;
  logic              cand_valid_unused, cand_gt_unused, cand_ge_thresh;
  logic              win;
  logic [FP_W-1:0]   cand_val;
  logic [IDX_W-1:0]  cand_idx;
  logic              cand_any;

  // Incoming beat against the current best.
  fp_pos_gt u_win_cmp (
    .a       (bus.in_data),
    .b       (best_val_q),
    .a_valid (beat_valid),
    .a_gt_b  (beat_gt),
    .a_ge_b  (beat_ge_unused)
  );

  // Post-beat winner against the confidence threshold.
  fp_pos_gt u_thr_cmp (
    .a       (cand_val),
    .b       (THRESH),
    .a_valid (cand_valid_unused),
    .a_gt_b  (cand_gt_unused),
    .a_ge_b  (cand_ge_thresh)
  );

  // Winner selection including the beat on the bus this cycle.
  always_comb begin
    accept      = bus.in_valid && bus.in_ready;
    at_end      = (cnt_q == LAST_IDX);
    frame_end   = accept && (bus.in_last || at_end);
    // Early in_last or a missing in_last at the final slot are both errors.
    frame_err   = bus.in_last ^ at_end;
    release_res = (state_q == HOLD) && bus.out_ready;
    // Strictly-greater keeps the lower index on ties.
    win         = beat_valid && (!any_valid_q || beat_gt);
    cand_val    = win ? bus.in_data : best_val_q;
    cand_idx    = win ? cnt_q : best_idx_q;
    cand_any    = any_valid_q || beat_valid;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (frame_end)     state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // State register and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus.in_ready  <= (state_d == COLLECT);
      bus.out_valid <= (state_d == HOLD);
    end
  end

  // Running argmax, frame counter and held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q             <= '0;
      best_val_q        <= FP_ZERO;
      best_idx_q        <= '0;
      any_valid_q       <= 1'b0;
      frame_count       <= '0;
      bus.out_index     <= '0;
      bus.out_value     <= FP_ZERO;
      bus.out_confident <= 1'b0;
      bus.out_err       <= 1'b0;
    end else if (release_res) begin
      cnt_q       <= '0;
      best_val_q  <= FP_ZERO;
      best_idx_q  <= '0;
      any_valid_q <= 1'b0;
      frame_count <= frame_count + 16'd1;
    end else if (accept) begin
      best_val_q  <= cand_val;
      best_idx_q  <= cand_idx;
      any_valid_q <= cand_any;
      if (!frame_end) begin
        cnt_q <= cnt_q + IDX_W'(1);
      end else begin
        // With no valid beat, cand_idx/cand_val are still the cleared 0s.
        bus.out_index     <= cand_idx;
        bus.out_value     <= cand_val;
        bus.out_confident <= cand_any && cand_ge_thresh;
        bus.out_err       <= frame_err || !cand_any;
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_argmax.sv
module tb_sigmoid_argmax;
  import sigmoid_pkg::*;

  localparam int unsigned N = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] frame_count;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_fc = 16'd0;
  logic [31:0] vals [N];

  sigmoid_argmax_if #(.NUM_CLASSES(N)) bus ();

  sigmoid_argmax #(.NUM_CLASSES(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < N; i++) vals[i] = v;
  endtask

  task automatic send_beat(input logic [31:0] data, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) send_beat(vals[i], i == last_at);
  endtask

  task automatic check_result(input string tag, input logic [31:0] idx, input logic [31:0] val,
                              input logic conf, input logic err);
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_idx"},   32'(bus.out_index), idx);
    check({tag, "_val"},   bus.out_value, val);
    check({tag, "_conf"},  32'(bus.out_confident), 32'(conf));
    check({tag, "_err"},   32'(bus.out_err), 32'(err));
  endtask

  task automatic accept_result(input string tag);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_fc++;
    check({tag, "_rel_in_ready"},  32'(bus.in_ready), 32'd1);
    check({tag, "_rel_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_frame_count"},   32'(frame_count), 32'(exp_fc));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready",  32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_fc",        32'(frame_count), 32'd0);
    check("rst_idx",       32'(bus.out_index), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_pre", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check("rel_in_ready_post", 32'(bus.in_ready), 32'd1);

    // 1: clear winner at index 1, one-cycle result latency
    fill(32'h3E80_0000);
    vals[0] = 32'h3F00_0000; vals[1] = 32'h3F40_0000; vals[2] = 32'h3F20_0000;
    send_frame(10, 9);
    check("t1_latency", 32'(bus.out_valid), 32'd1);
    check_result("t1", 32'd1, 32'h3F40_0000, 1'b1, 1'b0);
    accept_result("t1");

    // 2: all equal, first index wins
    fill(32'h3F19_999A);
    send_frame(10, 9);
    check_result("t2", 32'd0, 32'h3F19_999A, 1'b1, 1'b0);
    accept_result("t2");

    // 3: negative and NaN beats never win
    fill(32'h3E00_0000);
    vals[4] = 32'hBF80_0000; vals[5] = 32'h3E80_0000; vals[6] = 32'h7FC0_0000;
    send_frame(10, 9);
    check_result("t3", 32'd5, 32'h3E80_0000, 1'b0, 1'b0);
    accept_result("t3");

    // 4: short frame, then the next frame restarts at index 0
    vals[0] = 32'h3E00_0000; vals[1] = 32'h3E80_0000;
    vals[2] = 32'h3F60_0000; vals[3] = 32'h3F00_0000;
    send_frame(4, 3);
    check("t4_latency", 32'(bus.out_valid), 32'd1);
    check_result("t4", 32'd2, 32'h3F60_0000, 1'b1, 1'b1);
    accept_result("t4");
    fill(32'h3E80_0000);
    vals[0] = FP_ONE;
    send_frame(10, 9);
    check_result("t4b", 32'd0, FP_ONE, 1'b1, 1'b0);
    accept_result("t4b");

    // Missing in_last; value exactly at threshold is confident
    fill(FP_HALF);
    send_frame(10, -1);
    check_result("nolast", 32'd0, FP_HALF, 1'b1, 1'b1);
    accept_result("nolast");

    // No valid activation in the frame
    fill(32'hBF00_0000);
    vals[3] = 32'h7FC0_0000; vals[7] = 32'hFF80_0000;
    send_frame(10, 9);
    check_result("noval", 32'd0, FP_ZERO, 1'b0, 1'b1);
    accept_result("noval");

    // 5: +inf winner, then hold with out_ready low and in_valid high
    fill(32'h3E80_0000);
    vals[8] = 32'h7F80_0000;
    send_frame(10, 9);
    check_result("t5", 32'd8, 32'h7F80_0000, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = FP_ONE;
    bus.in_last  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("t5_hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("t5_hold_idx",      32'(bus.out_index), 32'd8);
    end
    check("t5_hold_val",   bus.out_value, 32'h7F80_0000);
    check("t5_hold_valid", 32'(bus.out_valid), 32'd1);
    accept_result("t5");
    fill(32'h3E00_0000);
    vals[3] = 32'h3F40_0000;
    send_frame(10, 9);
    check_result("t5b", 32'd3, 32'h3F40_0000, 1'b1, 1'b0);
    accept_result("t5b");

    // 6: reset mid-frame
    fill(32'h3E00_0000);
    for (int i = 0; i < 5; i++) send_beat(32'h3F70_0000, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("t6_rst_fc",       32'(frame_count), 32'd0);
    check("t6_rst_val",      bus.out_value, 32'd0);
    check("t6_rst_idx",      32'(bus.out_index), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_fc = 16'd0;
    @(posedge clk); #1;
    vals[2] = 32'h3F40_0000;
    send_frame(10, 9);
    check_result("t6", 32'd2, 32'h3F40_0000, 1'b1, 1'b0);
    accept_result("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
